// File: rtl/lbm_moment_ram.sv
// Purpose : register-based single-port moment store for the LBM lattice, with a parallel view of every word.
// Latency : one cycle from address to data_out; writes show up on mem_array the cycle after the edge.
// Backpressure : none; a read and an optional write are accepted on every clock.
module lbm_moment_ram #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 64
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         WE,
    input  logic [ADDRESS_WIDTH-1:0]     address,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0]        mem_array [0:DEPTH-1]
);

    // The address bus may be wider than the array needs; compare with one spare bit
    // so that DEPTH == 2**ADDRESS_WIDTH never overflows the bound.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q    [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_d    [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;
    logic                  addr_ok;

    // Decode whether the presented address maps onto a real lattice node.
    always_comb begin
        addr_ok = ({1'b0, address} < DEPTH_W);
    end

    // Next-state of the array and of the read register. The read uses the
    // pre-edge contents, so a same-address write returns the old word (read-first).
    always_comb begin
        mem_d    = mem_q;
        rd_dat_d = '0;
        if (addr_ok) begin
            rd_dat_d = mem_q[address];
            if (WE) begin
                mem_d[address] = data_in;
            end
        end
    end

    // State update; reset wins over a write in the same cycle and clears every word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_q    <= '{default: '0};
            rd_dat_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    // Stored bits are returned unchanged; signedness is only an interpretation.
    assign data_out  = $signed(rd_dat_q);
    assign mem_array = mem_q;

endmodule

// File: tb/tb_lbm_moment_ram.sv
// Bench for lbm_moment_ram: a reference array predicts every data_out word,
// predictions are queued at drive time and compared one clock later by a monitor.
// Direct mem_array checks cover visibility, isolation and reset clearing.
module tb_lbm_moment_ram;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 64;

    logic                 Clk;
    logic                 Reset;
    logic                 WE;
    logic [AW-1:0]        address;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;
    logic [DW-1:0]        mem_array [0:DEPTH-1];

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] model [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    lbm_moment_ram #(
        .DEPTH        (DEPTH),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .WE       (WE),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .mem_array(mem_array)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the word data_out will show after this edge.
    task automatic drive(input string tag, input logic rst, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        logic [DW-1:0] exp;
        Reset   = rst;
        WE      = we;
        address = addr;
        data_in = din;
        if (rst) begin
            exp = '0;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else begin
            exp = model[addr];
            if (we) model[addr] = din;
        end
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
    endtask

    // Monitor: each falling edge consumes the prediction for the preceding rising edge.
    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
        end
    end

    // Number of mem_array entries that are not zero.
    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_array[i] !== '0) n++;
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; WE = 1'b0; address = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Initial reset
        drive("init_reset", 1'b1, 1'b0, 8'h00, '0);
        check_eq("init_nonzero_words", DW'(count_nonzero()), '0);

        // 1: reset clears previously written words and data_out
        drive("t1_wr00", 1'b0, 1'b1, 8'h00, 64'h1234_5678_9ABC_DEF0);
        drive("t1_wrFF", 1'b0, 1'b1, 8'hFF, 64'h0FED_CBA9_8765_4321);
        drive("t1_rd00", 1'b0, 1'b0, 8'h00, '0);
        check_eq("t1_pre_mem00", mem_array[0],   64'h1234_5678_9ABC_DEF0);
        check_eq("t1_pre_memFF", mem_array[255], 64'h0FED_CBA9_8765_4321);
        drive("t1_reset", 1'b1, 1'b0, 8'hFF, '0);
        check_eq("t1_nonzero_words", DW'(count_nonzero()), '0);
        check_eq("t1_mem00", mem_array[0], '0);
        check_eq("t1_memFF", mem_array[255], '0);

        // 2: basic write then read of 1.0
        drive("t2_write", 1'b0, 1'b1, 8'h00, 64'h0100_0000_0000_0000);
        check_eq("t2_mem00", mem_array[0], 64'h0100_0000_0000_0000);
        drive("t2_read", 1'b0, 1'b0, 8'h00, '0);

        // 3: read-first on same address, then new word with address held
        drive("t3_wr5", 1'b0, 1'b1, 8'h10, 64'h5);
        drive("t3_rdw_old", 1'b0, 1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFE);
        drive("t3_new", 1'b0, 1'b0, 8'h10, '0);
        check_eq("t3_signed_neg2", DW'($signed(data_out) == -64'sd2), 64'd1);

        // 4: boundary addresses and isolation of neighbours
        drive("t4_wr00", 1'b0, 1'b1, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA);
        drive("t4_wrFF", 1'b0, 1'b1, 8'hFF, 64'h5555_5555_5555_5555);
        drive("t4_rd00", 1'b0, 1'b0, 8'h00, '0);
        drive("t4_rdFF", 1'b0, 1'b0, 8'hFF, '0);
        drive("t4_rd01", 1'b0, 1'b0, 8'h01, '0);
        drive("t4_rdFE", 1'b0, 1'b0, 8'hFE, '0);
        check_eq("t4_mem00", mem_array[0],   64'hAAAA_AAAA_AAAA_AAAA);
        check_eq("t4_memFF", mem_array[255], 64'h5555_5555_5555_5555);
        check_eq("t4_mem01", mem_array[1],   '0);
        check_eq("t4_memFE", mem_array[254], '0);

        // 5: reset has priority over a simultaneous write
        drive("t5_wr20", 1'b0, 1'b1, 8'h20, 64'h9);
        drive("t5_rst_we", 1'b1, 1'b1, 8'h20, 64'h7);
        check_eq("t5_mem20", mem_array[32], '0);
        drive("t5_rd20", 1'b0, 1'b0, 8'h20, '0);

        // 6: full sweep, write i*3 everywhere, then read everything back
        for (int i = 0; i < DEPTH; i++) begin
            drive("t6_write", 1'b0, 1'b1, AW'(i), DW'(i * 3));
        end
        check_eq("t6_mem80", mem_array[128], DW'(384));
        for (int i = 0; i < DEPTH; i++) begin
            drive("t6_read", 1'b0, 1'b0, AW'(i), '0);
        end
        drive("t6_tail", 1'b0, 1'b0, 8'h00, '0);

        // Let the monitor consume the last prediction
        @(negedge Clk);
        #1;
        check_eq("queue_drained", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
